// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: latches rising edges of source lines into sticky
// pending flags and drives a masked, registered level IRQ plus a small register port.
module irq_pending_ctrl #(
    parameter int NUM_SRC = 4
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [NUM_SRC-1:0] iSrc,
    input  logic [1:0]         iAddr,
    input  logic               iRead,
    input  logic               iWrite,
    input  logic [15:0]        iWriteData,
    output logic [15:0]        oReadData,
    output logic               oReadValid,
    output logic               oIRQ
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_OVERRUN = 2'd3;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] overrun;
    logic [NUM_SRC-1:0] srcPrev;

    logic [NUM_SRC-1:0] srcEvent;
    logic [NUM_SRC-1:0] writeBits;
    logic [NUM_SRC-1:0] clrPending;
    logic [NUM_SRC-1:0] clrOverrun;
    logic [NUM_SRC-1:0] pendingNext;
    logic [NUM_SRC-1:0] overrunNext;
    logic [NUM_SRC-1:0] maskNext;
    logic [15:0]        readMux;

    // Write-data bits above NUM_SRC have no register behind them.
    logic unusedWriteBits;
    assign unusedWriteBits = ^iWriteData;

    function automatic logic [15:0] widen(input logic [NUM_SRC-1:0] value);
        widen = '0;
        widen[NUM_SRC-1:0] = value;
    endfunction

    assign writeBits = iWriteData[NUM_SRC-1:0];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        srcEvent    = '0;
        clrPending  = '0;
        clrOverrun  = '0;
        pendingNext = '0;
        overrunNext = '0;
        maskNext    = mask;

        srcEvent = iSrc & ~srcPrev;
        if (iWrite && iAddr == ADDR_PENDING) clrPending = writeBits;
        if (iWrite && iAddr == ADDR_OVERRUN) clrOverrun = writeBits;
        if (iWrite && iAddr == ADDR_MASK)    maskNext   = writeBits;

        // A new edge beats a same-cycle clear; an edge that meets its own clear is not an overrun.
        pendingNext = srcEvent | (pending & ~clrPending);
        overrunNext = (srcEvent & pending & ~clrPending) | (overrun & ~clrOverrun);
    end

    always_comb begin
        readMux = '0;
        unique case (iAddr)
            ADDR_PENDING: readMux = widen(pending);
            ADDR_MASK:    readMux = widen(mask);
            ADDR_STATUS:  readMux = widen(pending & mask);
            ADDR_OVERRUN: readMux = widen(overrun);
            default:      readMux = '0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (iRST) begin
            pending    <= '0;
            mask       <= '0;
            overrun    <= '0;
            srcPrev    <= iSrc;
            oReadData  <= '0;
            oReadValid <= 1'b0;
            oIRQ       <= 1'b0;
        end else begin
            pending    <= pendingNext;
            mask       <= maskNext;
            overrun    <= overrunNext;
            srcPrev    <= iSrc;
            oReadValid <= iRead;
            oIRQ       <= |(pendingNext & maskNext);
            if (iRead) oReadData <= readMux;
        end
    end

endmodule
